cpu_sequencer: RTL



---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_handshake.sv | 48 ++++
 rtl/cpu_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the multi-cycle CPU control path.
//   - state_e      : sequencer FSM state encoding (3 bits, IDLE..ERROR)
//   - CTRL_*       : bit positions inside the instruction_control word
//   - OPCODE_*     : opcode field position inside the instruction
//   - XLEN         : datapath / address width
package cpu_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned OPCODE_MSB    = 31;
    localparam int unsigned OPCODE_LSB    = 26;
    localparam int unsigned CTRL_REGDST   = 7;
    localparam int unsigned CTRL_REGWRITE = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5,
        ST_ERROR     = 3'd6
    } state_e;

endpackage

// File: rtl/fetch_handshake.sv
// fetch_handshake: instruction-memory request/ack handshake with timeout.
//   clk, rst       : clock, synchronous active-high reset
//   fetch_active   : sequencer is in FETCH
//   imem_ack       : memory returns data this cycle
//   imem_req       : request to memory (high exactly while fetch_active)
//   fetch_done     : ack seen during FETCH
//   fetch_timeout  : FETCH_TIMEOUT-th consecutive FETCH cycle without ack
module fetch_handshake #(
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic fetch_active,
    input  logic imem_ack,
    output logic imem_req,
    output logic fetch_done,
    output logic fetch_timeout
);

    // The counter only needs to reach FETCH_TIMEOUT-1: the cycle that would
    // make it FETCH_TIMEOUT is the one that raises fetch_timeout.
    localparam int unsigned CW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(FETCH_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        imem_req      = fetch_active;
        fetch_done    = fetch_active & imem_ack;
        // Ack in the final allowed cycle wins over the timeout.
        fetch_timeout = fetch_active & ~imem_ack & (cnt_q == LAST);
        cnt_d         = cnt_q;
        if (!fetch_active || imem_ack || fetch_timeout) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the CPU datapath.
// Owns pc and ir; fetches over a req/ack handshake, then steps
// DECODE -> EXECUTE -> WRITEBACK, pulsing reg_we for one WRITEBACK cycle.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, halt_req     : run control
//   imem_req/addr/ack/rdata : instruction memory handshake
//   ctrl                : control word from instruction_control
//   pc, ir              : program counter, instruction register
//   reg_dst, reg_we     : write_register_mux select, register_file write enable
//   busy, halted, err   : status; state : FSM state for debug
//   instr_retired, cycle_count : performance counters
// Build option: define CPU_SEQ_PERF_CNT_EN to build the performance counters;
// otherwise both counter ports read as zero.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'd0,
    parameter logic [31:0] PC_STEP       = 32'd1,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [7:0]  ctrl,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        reg_dst,
    output logic        reg_we,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [2:0]  state,
    output logic [31:0] instr_retired,
    output logic [31:0] cycle_count
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic            reg_dst_q, reg_dst_d;
    logic            regwrite_q, regwrite_d;
    logic            halt_q, halt_d;
    logic            err_q, err_d;
    logic            fetch_done, fetch_timeout;
    logic            retire;
    logic            unused_ctrl_bits;

    assign unused_ctrl_bits = ^ctrl[6:1];

    fetch_handshake #(
        .FETCH_TIMEOUT(FETCH_TIMEOUT)
    ) u_fetch (
        .clk          (clk),
        .rst          (rst),
        .fetch_active (state_q == ST_FETCH),
        .imem_ack     (imem_ack),
        .imem_req     (imem_req),
        .fetch_done   (fetch_done),
        .fetch_timeout(fetch_timeout)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        reg_dst_d  = reg_dst_q;
        regwrite_d = regwrite_q;
        halt_d     = halt_q;
        err_d      = err_q;
        retire     = 1'b0;

        busy   = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                 (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK);
        halted = (state_q == ST_HALT);
        reg_we = (state_q == ST_WRITEBACK) & regwrite_q;

        // Halt requests during an instruction wait for its WRITEBACK.
        if (busy && halt_req) begin
            halt_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (fetch_done) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end else if (fetch_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: begin
                reg_dst_d  = ctrl[CTRL_REGDST];
                regwrite_d = ctrl[CTRL_REGWRITE];
                state_d    = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                retire  = 1'b1;
                pc_d    = pc_q + PC_STEP;
                // A request arriving in this very cycle still stops here.
                state_d = (halt_q || halt_req) ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                if (start) begin
                    halt_d  = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            reg_dst_q  <= 1'b0;
            regwrite_q <= 1'b0;
            halt_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            reg_dst_q  <= reg_dst_d;
            regwrite_q <= regwrite_d;
            halt_q     <= halt_d;
            err_q      <= err_d;
        end
    end

`ifdef CPU_SEQ_PERF_CNT_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] instr_retired_q, instr_retired_d;

    always_comb begin
        cycle_count_d   = cycle_count_q + {31'd0, busy};
        instr_retired_d = instr_retired_q + {31'd0, retire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_q   <= '0;
            instr_retired_q <= '0;
        end else begin
            cycle_count_q   <= cycle_count_d;
            instr_retired_q <= instr_retired_d;
        end
    end

    assign cycle_count   = cycle_count_q;
    assign instr_retired = instr_retired_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign cycle_count   = '0;
    assign instr_retired = '0;
`endif

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign reg_dst   = reg_dst_q;
    assign err       = err_q;
    assign state     = state_q;

endmodule
